// File: rtl/priority_arbiter_rr_if.sv
// rtl/priority_arbiter_rr_if.sv - request/grant bundle between N bus masters and the arbiter
//
// Signals:
//   req        N     request vector, req[i] = requester i wants the resource
//   mode_rr    1     0 = fixed priority (index 0 highest), 1 = round-robin
//   gnt        N     one-hot registered grant, all-zero when idle
//   gnt_valid  1     any grant active (== |gnt)
//   gnt_id     IDW   binary index of the granted requester, holds when idle
// Modports:
//   master  requester side (drives req/mode_rr)
//   slave   arbiter side (drives gnt/gnt_valid/gnt_id)

interface priority_arbiter_rr_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           mode_rr;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    modport master (
        output req,
        output mode_rr,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        input  mode_rr,
        output gnt,
        output gnt_valid,
        output gnt_id
    );
endinterface

// File: rtl/priority_arbiter_rr.sv
// rtl/priority_arbiter_rr.sv - N-way registered arbiter, fixed-priority or round-robin with hold limit
//
// Parameters:
//   N         number of requesters (2..32)
//   MAX_HOLD  max consecutive cycles one owner keeps the grant while others wait (>=1)
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-low
//   bus   slave modport of priority_arbiter_rr_if (req, mode_rr in; gnt, gnt_valid, gnt_id out)

module priority_arbiter_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_arbiter_rr_if.slave bus
);
    localparam int IDW  = $clog2(N);
    localparam int CNTW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // hold_cnt value at which a waiting competitor takes over
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

    logic [0:0]      state_q,    state_n;
    logic [N-1:0]    gnt_q,      gnt_n;
    logic [IDW-1:0]  gnt_id_q,   gnt_id_n;
    logic [IDW-1:0]  last_id_q,  last_id_n;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_n;

    logic [N-1:0]    cand;
    logic [N-1:0]    others;
    logic            owner_req;
    logic            arb;
    logic [IDW-1:0]  win;

    // Winner over a candidate set. Fixed: lowest set index. Round-robin:
    // first set index after last, wrapping modulo N.
    function automatic logic [IDW-1:0] pick(
        input logic [N-1:0]   c,
        input logic           rr,
        input logic [IDW-1:0] last
    );
        logic [IDW-1:0] w;
        logic           found;
        int             j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (rr) begin
                j = int'(last) + 1 + k;
                if (j >= N) begin
                    j = j - N;
                end
            end else begin
                j = k;
            end
            if (!found && c[j]) begin
                w     = IDW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // gnt_q is the one-hot of the owner while owned, so masking it off
    // leaves exactly the competing requests.
    assign owner_req = bus.req[gnt_id_q];
    assign others    = bus.req & ~gnt_q;

    always_comb begin
        state_n    = state_q;
        gnt_n      = gnt_q;
        gnt_id_n   = gnt_id_q;
        last_id_n  = last_id_q;
        hold_cnt_n = hold_cnt_q;
        cand       = bus.req;
        arb        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    arb = 1'b1;
                end
            end
            default: begin
                if (!owner_req) begin
                    // release; re-arbitrate on the same edge so hand-off has no bubble
                    if (|bus.req) begin
                        arb = 1'b1;
                    end else begin
                        state_n    = ST_IDLE;
                        gnt_n      = '0;
                        hold_cnt_n = '0;
                    end
                end else if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_n = hold_cnt_q + 1'b1;
                end else if (|others) begin
                    // hold limit reached under contention: owner is excluded
                    cand = others;
                    arb  = 1'b1;
                end
                // otherwise the lone owner keeps the grant, counter stays saturated
            end
        endcase

        win = pick(cand, bus.mode_rr, last_id_q);

        if (arb) begin
            state_n    = ST_OWNED;
            gnt_n      = {{(N-1){1'b0}}, 1'b1} << win;
            gnt_id_n   = win;
            last_id_n  = win;
            hold_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_id_q  <= IDW'(N - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_n;
            gnt_q      <= gnt_n;
            gnt_id_q   <= gnt_id_n;
            last_id_q  <= last_id_n;
            hold_cnt_q <= hold_cnt_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = gnt_id_q;
endmodule
